// File: rtl/alu_seq_if.sv
// Request/result bundle between the operand register bank, alu_seq and the result bus.
// The master issues operations; the slave (alu_seq) returns registered results and status.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] R_hi;
  logic             zero;
  logic             sign;
  logic             c_out;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, c_in,
    input  R, R_hi, zero, sign, c_out, err, busy, done
  );

  modport slave (
    input  start, op, A, B, c_in,
    output R, R_hi, zero, sign, c_out, err, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: single-cycle add/sub/logic ops plus a WIDTH-cycle
// LSB-first shift-add unsigned multiplier behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_mcand, w_mcand_nx;
  logic [WIDTH-1:0]   r_mplr, w_mplr_nx;
  logic [WIDTH-1:0]   r_acc_hi, w_acc_hi_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [WIDTH-1:0]   r_res, w_res_nx;
  logic [WIDTH-1:0]   r_res_hi, w_res_hi_nx;
  logic               r_zero, w_zero_nx;
  logic               r_sign, w_sign_nx;
  logic               r_cout, w_cout_nx;
  logic               r_err, w_err_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;

  logic [WIDTH:0]     w_ext;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_cout;
  logic               w_alu_err;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_prod;

  // Single-cycle result from the live bus operands (only used on the start edge)
  always_comb begin
    w_ext      = {(WIDTH+1){1'b0}};
    w_alu_res  = {WIDTH{1'b0}};
    w_alu_cout = 1'b0;
    w_alu_err  = 1'b0;
    case (bus.op)
      3'b000: begin
        w_ext      = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.c_in};
        w_alu_res  = w_ext[WIDTH-1:0];
        w_alu_cout = w_ext[WIDTH];
      end
      3'b001: begin
        w_ext      = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, bus.c_in};
        w_alu_res  = w_ext[WIDTH-1:0];
        w_alu_cout = w_ext[WIDTH];
      end
      3'b010:  w_alu_res = bus.A & bus.B;
      3'b011:  w_alu_res = bus.A | bus.B;
      3'b100:  w_alu_res = bus.A ^ bus.B;
      3'b101:  w_alu_res = ~bus.A;
      3'b110:  w_alu_res = {WIDTH{1'b0}};
      default: w_alu_err = 1'b1;
    endcase
  end

  // One shift-add step; the multiplier register fills with the product low half as it shifts out
  always_comb begin
    if (r_mplr[0]) begin
      w_msum = {1'b0, r_acc_hi} + {1'b0, r_mcand};
    end else begin
      w_msum = {1'b0, r_acc_hi};
    end
    w_prod = {w_msum, r_mplr[WIDTH-1:1]};
  end

  // Next-state and output-register decode
  always_comb begin
    w_state_nx  = r_state;
    w_mcand_nx  = r_mcand;
    w_mplr_nx   = r_mplr;
    w_acc_hi_nx = r_acc_hi;
    w_cnt_nx    = r_cnt;
    w_res_nx    = r_res;
    w_res_hi_nx = r_res_hi;
    w_zero_nx   = r_zero;
    w_sign_nx   = r_sign;
    w_cout_nx   = r_cout;
    w_err_nx    = r_err;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && (bus.op == 3'b110)) begin
          w_mcand_nx  = bus.A;
          w_mplr_nx   = bus.B;
          w_acc_hi_nx = {WIDTH{1'b0}};
          w_cnt_nx    = {CNT_W{1'b0}};
          w_busy_nx   = 1'b1;
          w_state_nx  = ST_MUL;
        end else if (bus.start) begin
          w_res_nx    = w_alu_res;
          w_res_hi_nx = {WIDTH{1'b0}};
          w_zero_nx   = (w_alu_res == {WIDTH{1'b0}});
          w_sign_nx   = w_alu_res[WIDTH-1];
          w_cout_nx   = w_alu_cout;
          w_err_nx    = w_alu_err;
          w_done_nx   = 1'b1;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_acc_hi_nx = w_msum[WIDTH:1];
        w_mplr_nx   = {w_msum[0], r_mplr[WIDTH-1:1]};
        w_cnt_nx    = r_cnt + CNT_W'(1);
        // r_cnt still holds the pre-increment value, so this edge is the WIDTH-th step
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_res_nx    = w_prod[WIDTH-1:0];
          w_res_hi_nx = w_prod[2*WIDTH-1:WIDTH];
          w_zero_nx   = (w_prod == {(2*WIDTH){1'b0}});
          w_sign_nx   = w_prod[2*WIDTH-1];
          w_cout_nx   = 1'b0;
          w_err_nx    = 1'b0;
          w_busy_nx   = 1'b0;
          w_done_nx   = 1'b1;
          w_state_nx  = ST_IDLE;
        end else begin
          w_state_nx  = ST_MUL;
        end
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= {WIDTH{1'b0}};
      r_mplr   <= {WIDTH{1'b0}};
      r_acc_hi <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_res    <= {WIDTH{1'b0}};
      r_res_hi <= {WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_sign   <= 1'b0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_mcand  <= w_mcand_nx;
      r_mplr   <= w_mplr_nx;
      r_acc_hi <= w_acc_hi_nx;
      r_cnt    <= w_cnt_nx;
      r_res    <= w_res_nx;
      r_res_hi <= w_res_hi_nx;
      r_zero   <= w_zero_nx;
      r_sign   <= w_sign_nx;
      r_cout   <= w_cout_nx;
      r_err    <= w_err_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  assign bus.R     = r_res;
  assign bus.R_hi  = r_res_hi;
  assign bus.zero  = r_zero;
  assign bus.sign  = r_sign;
  assign bus.c_out = r_cout;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;
  localparam int W = 8;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   done_seen;
  int   busy_seen;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.c_in  = ci;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.A      = 8'h00;
    bus.B      = 8'h00;
    bus.c_in   = 1'b0;
    tick();
    tick();
    chk("rst_flags", {bus.zero, bus.sign, bus.c_out, bus.err, bus.busy, bus.done}, 16'h0000);
    chk("rst_res", {bus.R_hi, bus.R}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // ADD FF+01 -> wraps to 0 with carry
    issue(3'b000, 8'hFF, 8'h01, 1'b0);
    chk("add_R", bus.R, 16'h0000);
    chk("add_cout", bus.c_out, 16'h0001);
    chk("add_zero", bus.zero, 16'h0001);
    chk("add_sign", bus.sign, 16'h0000);
    chk("add_done", bus.done, 16'h0001);
    chk("add_busy", bus.busy, 16'h0000);
    tick();
    chk("add_done_drop", bus.done, 16'h0000);

    // SUB 05-07 -> FE, no carry
    issue(3'b001, 8'h05, 8'h07, 1'b1);
    chk("sub_R", bus.R, 16'h00FE);
    chk("sub_flags", {bus.c_out, bus.sign, bus.zero}, 16'h0002);

    // XOR AA^AA -> 0
    issue(3'b100, 8'hAA, 8'hAA, 1'b1);
    chk("xor_R", bus.R, 16'h0000);
    chk("xor_flags", {bus.c_out, bus.sign, bus.zero}, 16'h0001);
    tick();

    // MUL FF*FF = FE01, busy exactly 8 cycles
    issue(3'b110, 8'hFF, 8'hFF, 1'b0);
    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.busy) busy_seen++;
      if (bus.done) done_seen++;
      tick();
    end
    if (bus.busy) busy_seen++;
    if (bus.done) done_seen++;
    chk("mul_busy_cycles", 16'(busy_seen), 16'd8);
    chk("mul_no_early_done", 16'(done_seen), 16'd0);
    tick();
    chk("mul_done", {bus.done, bus.busy}, 16'h0002);
    chk("mul_prod", {bus.R_hi, bus.R}, 16'hFE01);
    chk("mul_flags", {bus.c_out, bus.sign, bus.zero}, 16'h0002);
    tick();
    chk("mul_done_drop", bus.done, 16'h0000);

    // MUL 00*37 -> zero
    issue(3'b110, 8'h00, 8'h37, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("mul0_done", bus.done, 16'h0000);
    tick();
    chk("mul0_done_late", bus.done, 16'h0001);
    chk("mul0_prod", {bus.R_hi, bus.R}, 16'h0000);
    chk("mul0_flags", {bus.sign, bus.zero}, 16'h0001);
    tick();

    // MUL 0C*0A with an ADD pulsed mid-run, then back-to-back ADD on the done cycle
    issue(3'b110, 8'h0C, 8'h0A, 1'b0);
    bus.A = 8'h33;
    bus.B = 8'h55;
    tick();
    tick();
    issue(3'b000, 8'h01, 8'h01, 1'b0);
    chk("ign_done", bus.done, 16'h0000);
    chk("ign_R", bus.R, 16'h0000);
    chk("ign_busy", bus.busy, 16'h0001);
    for (int i = 0; i < 4; i++) tick();
    chk("mul78_pending", bus.done, 16'h0000);
    tick();
    chk("mul78_done", bus.done, 16'h0001);
    chk("mul78_prod", {bus.R_hi, bus.R}, 16'h0078);
    issue(3'b000, 8'h01, 8'h01, 1'b0);
    chk("b2b_R", bus.R, 16'h0002);
    chk("b2b_done", bus.done, 16'h0001);
    chk("b2b_hi", bus.R_hi, 16'h0000);
    tick();

    // Asynchronous reset in cycle 4 of a multiply
    issue(3'b110, 8'hFF, 8'hFF, 1'b0);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_res", {bus.R_hi, bus.R}, 16'h0000);
    chk("arst_flags", {bus.zero, bus.sign, bus.c_out, bus.err, bus.busy, bus.done}, 16'h0000);
    tick();
    reset_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    chk("arst_no_done", 16'(done_seen), 16'd0);
    chk("arst_no_busy", 16'(busy_seen), 16'd0);

    // Reserved opcode, then AND clears err
    issue(3'b111, 8'h12, 8'h34, 1'b1);
    chk("rsv_res", {bus.R_hi, bus.R}, 16'h0000);
    chk("rsv_flags", {bus.err, bus.zero, bus.sign, bus.c_out, bus.done}, 16'h0019);
    issue(3'b010, 8'hF0, 8'h3C, 1'b0);
    chk("and_R", bus.R, 16'h0030);
    chk("and_flags", {bus.err, bus.zero, bus.sign, bus.c_out, bus.done}, 16'h0001);

    // OR and NOTA for the remaining opcodes
    issue(3'b011, 8'h81, 8'h42, 1'b0);
    chk("or_R", {bus.sign, bus.R}, 16'h01C3);
    issue(3'b101, 8'h0F, 8'h00, 1'b0);
    chk("nota_R", {bus.sign, bus.R}, 16'h01F0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
